iopmp_err_responder: RTL
========================

# iopmp_err_responder

Terminating AXI responder for transactions the IOPMP denies. It sits on the deny port of the IOPMP checker and consumes `ariane_axi_soc::req_nsaid_t` requests. Every transaction is completed protocol-correctly with an error response: all W beats are drained, a B is returned, and len+1 R beats are returned. The first denied transaction is latched into an error record for software, and a running deny count is kept.

## Interface
Parameters:
- `ErrResp`, default `axi_pkg::RESP_DECERR`: resp code driven on every B and R.
- `CntWidth`, default 16: width of the saturating deny counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  `req_nsaid_t`  denied-path AXI request, including `aw.nsaid` and `ar.nsaid`.
- `resp_o`  out  `resp_t`  AXI response.
- `err_clear_i`  in  1  one-cycle pulse that clears the error record and the counter.
- `err_valid_o`  out  1  error record holds a captured transaction.
- `err_write_o`  out  1  captured transaction was AW (1) or AR (0).
- `err_nsaid_o`  out  4  captured nsaid.
- `err_addr_o`  out  64  captured address.
- `err_id_o`  out  `IdWidth`  captured AXI id.
- `err_cnt_o`  out  `CntWidth`  saturating count of denied transactions.

## Operation
- Write FSM has three states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: `aw_ready`=1, `w_ready`=0. An AW handshake latches id and moves to W_DATA.
  - W_DATA: `w_ready`=1. Beats are discarded; `len` is ignored and only `w.last` is honoured. A handshake with `w.last` moves to W_RESP.
  - W_RESP: `b_valid`=1, `b.id`=latched id, `b.resp`=ErrResp, `b.user`=0. A `b_ready` handshake moves to W_IDLE.
- Read FSM has two states: R_IDLE, R_DATA.
  - R_IDLE: `ar_ready`=1. An AR handshake latches id, loads the beat counter with `ar.len`, and moves to R_DATA.
  - R_DATA: `r_valid`=1, `r.data`=0, `r.user`=0, `r.resp`=ErrResp, `r.id`=latched id, `r.last`=(counter==0).
  - Each `r_ready` handshake decrements the counter. A handshake with last set moves to R_IDLE.
- The two FSMs are fully independent. Read and write can be in flight simultaneously. Each channel has one transaction outstanding.
- `aw.atop` is ignored; atomics are filtered upstream.
- Error capture:
  - Captures on an AW or AR handshake when `err_valid_o`=0, or when `err_clear_i`=1 in the same cycle (capture wins; valid stays 1).
  - If AW and AR handshake in the same cycle, AW is captured.
  - Once `err_valid_o`=1 the record is frozen (first error wins) until cleared.
- Counter:
  - Adds the number of AW/AR handshakes in the cycle (0, 1 or 2) and saturates at all-ones.
  - `err_clear_i` sets it to the handshake count of that same cycle.

## Timing
- Reset: both FSMs idle, counter 0, record 0. Resulting outputs: `aw_ready`=1, `ar_ready`=1, `w_ready`=0, `b_valid`=0, `r_valid`=0, `err_valid_o`=0, `err_cnt_o`=0. Every other field is 0.
- All outputs are decoded from registered state only. There is no combinational path from `req_i` valid or ready signals to `resp_o`.
- Write path:
  - AW handshake at cycle N: `w_ready`=1 from N+1.
  - Last W at cycle M: `b_valid`=1 at M+1.
  - B handshake at cycle K: `aw_ready`=1 at K+1.
  - W beats presented before AW are stalled (`w_ready`=0).
- Read path:
  - AR handshake at cycle N: first R beat valid at N+1.
  - With `r_ready` held high, beats are back-to-back and there are len+1 beats total. `len`=0 gives a single beat with last=1.
  - `len`=255 needs an 8-bit counter with no wrap.
- `r_valid` and `b_valid` stay high with stable payload until their handshake completes.
- Error record and counter outputs update one cycle after the handshake.
- Reset mid-burst aborts immediately to the idle states. No partial response is completed.

## Structure
- `iopmp_err_rec_t` goes in `ariane_axi_soc`: a packed struct {write, nsaid, addr, id}.
- `ErrResp` default comes from `axi_pkg`.
- FSM state enums stay local to the module.
- Single flat module, no sub-modules.

## Test plan
- AW id=3, len=3, 4 W beats with last on the 4th. Required: exactly 4 `w_ready` handshakes, then B id=3 resp=2'b11. `err_write_o`=1, `err_nsaid_o`=aw.nsaid, `err_cnt_o`=1.
- AR id=5, len=7, `r_ready` toggling every other cycle. Required: exactly 8 beats, id=5, resp=DECERR, data=0, last only on the 8th beat. `r_valid` stays high through stalls.
- AW (nsaid=2) and AR (nsaid=9) handshake in the same cycle with the record empty. Required: record captures the AW (nsaid=2, write=1), counter=2, and both bursts complete concurrently.
- Second AR after capture, then `err_clear_i` pulsed alone, then a new AR with nsaid=7. Required: the record stays frozen on the first error, then clears to valid=0 and count=0, then captures nsaid=7 with count=1.
- Counter preloaded near all-ones via a long AR stream with `CntWidth`=4. Required: saturates at 15 and does not wrap.
- Assert `rst_ni` low mid R burst (beat 3 of 8). Required: `r_valid`=0 asynchronously, `ar_ready`=1, and the next AR starts a fresh burst.

Source files
------------

// File: rtl/ariane_axi_soc.sv
// SoC AXI channel structs, including the nsaid-tagged request used behind the IOPMP.
package ariane_axi_soc;

  localparam int unsigned IdWidth    = 4;
  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned DataWidth  = 64;
  localparam int unsigned UserWidth  = 1;
  localparam int unsigned NsaidWidth = 4;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;
  typedef logic [NsaidWidth-1:0]  nsaid_t;

  typedef struct packed {
    id_t              id;
    addr_t            addr;
    axi_pkg::len_t    len;
    axi_pkg::size_t   size;
    axi_pkg::burst_t  burst;
    logic             lock;
    axi_pkg::cache_t  cache;
    axi_pkg::prot_t   prot;
    axi_pkg::qos_t    qos;
    axi_pkg::region_t region;
    axi_pkg::atop_t   atop;
    user_t            user;
    nsaid_t           nsaid;
  } aw_chan_nsaid_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t            id;
    axi_pkg::resp_t resp;
    user_t          user;
  } b_chan_t;

  typedef struct packed {
    id_t              id;
    addr_t            addr;
    axi_pkg::len_t    len;
    axi_pkg::size_t   size;
    axi_pkg::burst_t  burst;
    logic             lock;
    axi_pkg::cache_t  cache;
    axi_pkg::prot_t   prot;
    axi_pkg::qos_t    qos;
    axi_pkg::region_t region;
    user_t            user;
    nsaid_t           nsaid;
  } ar_chan_nsaid_t;

  typedef struct packed {
    id_t            id;
    data_t          data;
    axi_pkg::resp_t resp;
    logic           last;
    user_t          user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_nsaid_t aw;
    logic           aw_valid;
    w_chan_t        w;
    logic           w_valid;
    logic           b_ready;
    ar_chan_nsaid_t ar;
    logic           ar_valid;
    logic           r_ready;
  } req_nsaid_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    logic   write;
    nsaid_t nsaid;
    addr_t  addr;
    id_t    id;
  } iopmp_err_rec_t;

endpackage

// File: rtl/axi_pkg.sv
// AXI4 base types and response codes shared by the SoC interconnect.
package axi_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [3:0] cache_t;
  typedef logic [2:0] prot_t;
  typedef logic [3:0] qos_t;
  typedef logic [3:0] region_t;
  typedef logic [5:0] atop_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/iopmp_err_responder.sv
// Terminates IOPMP-denied AXI transactions with error responses and records
// the first denial plus a saturating deny count for software.
module iopmp_err_responder
  import ariane_axi_soc::*;
#(
  parameter axi_pkg::resp_t ErrResp  = axi_pkg::RESP_DECERR,
  parameter int unsigned    CntWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  req_nsaid_t            req_i,
  output resp_t                 resp_o,
  input  logic                  err_clear_i,
  output logic                  err_valid_o,
  output logic                  err_write_o,
  output logic [NsaidWidth-1:0] err_nsaid_o,
  output logic [AddrWidth-1:0]  err_addr_o,
  output logic [IdWidth-1:0]    err_id_o,
  output logic [CntWidth-1:0]   err_cnt_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;
  typedef enum logic       {R_IDLE, R_DATA}         rState_e;

  wState_e        wState_q;
  rState_e        rState_q;
  id_t            wId_q;
  id_t            rId_q;
  logic [7:0]     beatCnt_q;

  iopmp_err_rec_t rec_q, rec_d;
  logic           errValid_q, errValid_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cntBase;
  logic [CntWidth:0]   cntSum;

  logic       awHs, arHs;
  logic [1:0] hsNum;
  logic       unusedReq;

  assign awHs  = req_i.aw_valid && (wState_q == W_IDLE);
  assign arHs  = req_i.ar_valid && (rState_q == R_IDLE);
  assign hsNum = {1'b0, awHs} + {1'b0, arHs};

  // Payload, data and most AW/AR attributes are deliberately discarded.
  assign unusedReq = ^req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wState_q <= W_IDLE;
      wId_q    <= '0;
    end else begin
      unique case (wState_q)
        W_IDLE: if (req_i.aw_valid) begin
          wId_q    <= req_i.aw.id;
          wState_q <= W_DATA;
        end
        W_DATA: if (req_i.w_valid && req_i.w.last) wState_q <= W_RESP;
        W_RESP: if (req_i.b_ready) wState_q <= W_IDLE;
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // beatCnt_q holds the beats remaining after the one currently presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rState_q  <= R_IDLE;
      rId_q     <= '0;
      beatCnt_q <= '0;
    end else begin
      unique case (rState_q)
        R_IDLE: if (req_i.ar_valid) begin
          rId_q     <= req_i.ar.id;
          beatCnt_q <= req_i.ar.len;
          rState_q  <= R_DATA;
        end
        R_DATA: if (req_i.r_ready) begin
          if (beatCnt_q == 8'd0) rState_q  <= R_IDLE;
          else                   beatCnt_q <= beatCnt_q - 8'd1;
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  // Payload fields are only non-zero while the matching valid is up.
  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = (wState_q == W_IDLE);
    resp_o.w_ready  = (wState_q == W_DATA);
    resp_o.ar_ready = (rState_q == R_IDLE);
    if (wState_q == W_RESP) begin
      resp_o.b_valid = 1'b1;
      resp_o.b.id    = wId_q;
      resp_o.b.resp  = ErrResp;
    end
    if (rState_q == R_DATA) begin
      resp_o.r_valid = 1'b1;
      resp_o.r.id    = rId_q;
      resp_o.r.resp  = ErrResp;
      resp_o.r.last  = (beatCnt_q == 8'd0);
    end
  end

  // A clear in the same cycle as a handshake reopens the record for that handshake.
  always_comb begin
    rec_d      = rec_q;
    errValid_d = errValid_q;
    if (err_clear_i) begin
      rec_d      = '0;
      errValid_d = 1'b0;
    end
    if ((awHs || arHs) && (!errValid_q || err_clear_i)) begin
      errValid_d = 1'b1;
      if (awHs) begin
        rec_d = '{write: 1'b1, nsaid: req_i.aw.nsaid, addr: req_i.aw.addr, id: req_i.aw.id};
      end else begin
        rec_d = '{write: 1'b0, nsaid: req_i.ar.nsaid, addr: req_i.ar.addr, id: req_i.ar.id};
      end
    end
  end

  always_comb begin
    cntBase = err_clear_i ? '0 : cnt_q;
    cntSum  = {1'b0, cntBase} + (CntWidth+1)'(hsNum);
    cnt_d   = cntSum[CntWidth] ? '1 : cntSum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_q      <= '0;
      errValid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rec_q      <= rec_d;
      errValid_q <= errValid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err_valid_o = errValid_q;
  assign err_write_o = rec_q.write;
  assign err_nsaid_o = rec_q.nsaid;
  assign err_addr_o  = rec_q.addr;
  assign err_id_o    = rec_q.id;
  assign err_cnt_o   = cnt_q;

endmodule
